// File: rtl/muldiv_sequencer.sv
// Iterative MUL/MULH/DIV/REM sequencer: shift-add multiply, restoring divide (MULDIV_EARLY_OUT_EN: MUL/MULH early exit).
// Latency: XLEN+2 cycles start-to-done; DIV/REM by zero and overflow finish in 1 cycle.
// Backpressure: stall holds the pipeline while an op is accepted or running; start is ignored while busy.
module muldiv_sequencer #(
    parameter  int XLEN = 32,
    localparam int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [1:0]        OP_MUL  = 2'b00;
    localparam logic [1:0]        OP_MULH = 2'b01;
    localparam logic [1:0]        OP_DIV  = 2'b10;
    localparam logic [XLEN-1:0]   ONE     = 1;
    localparam logic [2*XLEN-1:0] ONE2    = 1;
    localparam logic [XLEN-1:0]   INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [1:0]        op_q, op_nxt;
    logic [CNTW-1:0]   cnt, cnt_nxt;
    logic [2*XLEN-1:0] acc, acc_nxt;
    logic [2*XLEN-1:0] mcand, mcand_nxt;
    logic [XLEN-1:0]   mplier, mplier_nxt;
    logic              sgn, sgn_nxt;
    logic [XLEN-1:0]   result_nxt;

    logic              accept;
    logic [XLEN-1:0]   a_abs, b_abs, mpl_init;
    logic [XLEN:0]     rem_sh, diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_val;

    assign a_abs  = a[XLEN-1] ? (~a + ONE) : a;
    assign b_abs  = b[XLEN-1] ? (~b + ONE) : b;
    assign accept = start & ~kill & ((state == S_IDLE) | (state == S_DONE));
    assign stall  = accept | busy;

    // Divide state lives in acc low word (remainder) and mplier (dividend out / quotient in).
    assign rem_sh   = {acc[XLEN-1:0], mplier[XLEN-1]};
    assign diff     = rem_sh - {1'b0, mcand[XLEN-1:0]};
    assign prod_fix = sgn ? (~acc + ONE2) : acc;
    assign mpl_init = (op == OP_MUL) ? b : (op[1] ? a_abs : b_abs);

    always_comb begin
        case (op_q)
            OP_MUL:  fix_val = acc[XLEN-1:0];
            OP_MULH: fix_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV:  fix_val = sgn ? (~mplier + ONE) : mplier;
            default: fix_val = sgn ? (~acc[XLEN-1:0] + ONE) : acc[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_nxt  = state;
        op_nxt     = op_q;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        sgn_nxt    = sgn;
        result_nxt = result;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    op_nxt = op;
                    if (op[1] && (b == '0)) begin
                        state_nxt  = S_DONE;
                        result_nxt = op[0] ? a : '1;
                    end else if (op[1] && (a == INT_MIN) && (b == '1)) begin
                        state_nxt  = S_DONE;
                        result_nxt = op[0] ? '0 : a;
                    end else begin
                        state_nxt  = S_CALC;
                        cnt_nxt    = CNTW'(XLEN);
                        acc_nxt    = '0;
                        mplier_nxt = mpl_init;
                        if (op == OP_MUL) begin
                            mcand_nxt = {{XLEN{1'b0}}, a};
                            sgn_nxt   = 1'b0;
                        end else begin
                            mcand_nxt = {{XLEN{1'b0}}, op[1] ? b_abs : a_abs};
                            sgn_nxt   = (op == 2'b11) ? a[XLEN-1] : (a[XLEN-1] ^ b[XLEN-1]);
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        if (!op[1] && (mpl_init == '0)) state_nxt = S_FIX;
`endif
                    end
                end
            end
            S_CALC: begin
                cnt_nxt = cnt - CNTW'(1);
                if (op_q[1]) begin
                    if (!diff[XLEN]) begin
                        acc_nxt    = {{XLEN{1'b0}}, diff[XLEN-1:0]};
                        mplier_nxt = {mplier[XLEN-2:0], 1'b1};
                    end else begin
                        acc_nxt    = {{XLEN{1'b0}}, rem_sh[XLEN-1:0]};
                        mplier_nxt = {mplier[XLEN-2:0], 1'b0};
                    end
                end else begin
                    if (mplier[0]) acc_nxt = acc + mcand;
                    mcand_nxt  = mcand << 1;
                    mplier_nxt = mplier >> 1;
                end
                if (cnt == CNTW'(1)) state_nxt = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                if (!op_q[1] && ((mplier >> 1) == '0)) state_nxt = S_FIX;
`endif
            end
            S_FIX: begin
                state_nxt  = S_DONE;
                result_nxt = fix_val;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Flush wins over everything, including a finishing FIX.
        if (kill) begin
            state_nxt  = S_IDLE;
            result_nxt = result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            sgn    <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            op_q   <= op_nxt;
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            sgn    <= sgn_nxt;
            result <= result_nxt;
            busy   <= (state_nxt == S_CALC) | (state_nxt == S_FIX);
            done   <= (state_nxt == S_DONE);
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors push expected result and latency; a monitor checks each done.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            kill = 1'b0;
    logic            stall, busy, done;
    logic [XLEN-1:0] result;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
        int              issue;
        string           name;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              failures = 0;
    int              cyc = 0;
    logic [XLEN-1:0] last_res = '0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .kill(kill), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 result=0x%08h expected no done", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_latency"}, XLEN'(cyc - e.issue), XLEN'(e.lat));
            end
        end
    end

    // Raise start so the next rising edge accepts it; drop it one edge later.
    task automatic issue(input string name, input logic [1:0] o, input logic [XLEN-1:0] va,
                         input logic [XLEN-1:0] vb, input logic [XLEN-1:0] res, input int lat,
                         input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1; op = o; a = va; b = vb;
        if (push) begin
            e.res = res; e.lat = lat; e.issue = cyc; e.name = name;
            sb.push_back(e);
            last_res = res;
        end
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        int n;
        #12;
        check("reset_busy", XLEN'(busy), 0);
        check("reset_done", XLEN'(done), 0);
        check("reset_result", result, 0);
        check("reset_stall", XLEN'(stall), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // MUL with stall window check
        issue("mul_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (i == 0 || i == 32) check("mul_stall_high", XLEN'(stall), 1);
        end
        @(negedge clk);
        check("mul_stall_low_at_done", XLEN'(stall), 0);
        drain();

        issue("mulh_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b1); drain();
        issue("mulh_m1_1",    2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34, 1'b1); drain();
        issue("div_m7_2",     2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b1); drain();
        issue("rem_m7_2",     2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b1); drain();
        issue("div_100_m7",   2'b10, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 1'b1); drain();
        issue("rem_100_m7",   2'b11, 32'd100,       32'hFFFF_FFF9, 32'd2,         34, 1'b1); drain();
        issue("div_5_0",      2'b10, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b1); drain();
        issue("rem_5_0",      2'b11, 32'd5,         32'd0,         32'd5,         1,  1'b1); drain();
        issue("div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b1); drain();
        issue("rem_ovf",      2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b1); drain();

        // Kill mid-divide: no done, busy drops, result holds
        issue("div_killed", 2'b10, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        repeat (8) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check("kill_busy", XLEN'(busy), 0);
        check("kill_done", XLEN'(done), 0);
        check("kill_result_held", result, last_res);
        repeat (40) @(posedge clk);
        check("kill_result_after", result, last_res);
        issue("div_after_kill", 2'b10, 32'd100, 32'd7, 32'd14, 34, 1'b1); drain();

        // Back-to-back: new start presented during the DONE cycle
        issue("mul_b2b_first", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL b2b_wait_done: got done=0 expected done=1");
        end
        begin
            exp_t e;
            start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
            e.res = 32'd12; e.lat = 34; e.issue = cyc; e.name = "mul_b2b_second";
            sb.push_back(e);
        end
        #1 check("b2b_stall_on_done", XLEN'(stall), 1);
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", XLEN'(busy), 1);
        drain();

        // Asynchronous reset in the middle of CALC
        issue("div_reset", 2'b10, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", XLEN'(busy), 0);
        check("arst_done", XLEN'(done), 0);
        check("arst_result", result, 0);
        check("arst_stall", XLEN'(stall), 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("div_after_reset", 2'b10, 32'd1000, 32'd3, 32'd333, 34, 1'b1); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the execute stage's MUL, MULH, DIV and REM operations. The 32-bit execute ALU performs only single-cycle operations.
- Captures operands on a start request, then runs an iterative shift-add multiply or restoring divide. It stalls the pipeline while busy and returns a registered result with a one-cycle done pulse.
- Control decode raises start when AluFun selects MUL, MULH, DIV or REM. Writeback takes the result when done is high.

Parameters:
- XLEN, 32, operand and result width; must be even and at least 8.
- CNTW, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled when state is IDLE or DONE.
- op  in  2  operation: 00 MUL (low word), 01 MULH (signed x signed, high word), 10 DIV (signed), 11 REM (signed).
- a  in  XLEN  rs1 operand; captured on accepted start.
- b  in  XLEN  rs2 operand; captured on accepted start.
- kill  in  1  pipeline flush; aborts any operation in progress.
- stall  out  1  combinational pipeline hold request.
- busy  out  1  registered; high in CALC and FIX.
- done  out  1  registered; one-cycle pulse, result valid.
- result  out  XLEN  registered result; held until the next done.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy 0, done 0, result 0, counter 0, internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE with start=1 and kill=0: latch op, a and b, then branch.
  - DIV/REM with b==0: go to DONE. DIV result is all-ones; REM result is a.
  - DIV/REM with a==100..0 and b==all-ones (overflow): go to DONE. DIV result is a; REM result is 0.
  - All other cases: take absolute values (signed ops), record the result sign, load counter=XLEN, go to CALC.
- IDLE or DONE with start=0: go to, or stay in, IDLE.
- CALC: one iteration per cycle.
  - Multiply: one shift-add step into a 2*XLEN accumulator.
  - Divide: one restoring shift-subtract step producing one quotient bit.
  - Counter decrements each cycle; at counter==1, go to FIX.
- FIX: apply sign correction. Write the selected word to result, set done=1 for the next cycle, go to DONE.
  - MUL: low XLEN bits of the unsigned product; equals the signed product's low word.
  - MULH: product negated if operand signs differ, high XLEN bits.
  - DIV: quotient negated if operand signs differ.
  - REM: remainder takes the sign of a.
- DONE: done=1 for exactly one cycle. Back-to-back start is accepted here, giving no idle bubble.
- Latency: for a start sampled at edge N, done is high in the cycle after edge N+XLEN+1, i.e. XLEN+2 cycles. Special cases (b==0, overflow) take 1 cycle: done in the cycle after edge N.
- stall = (start & (state==IDLE | state==DONE) & ~kill) | busy. stall is low while done is high.
- start while in CALC or FIX: ignored; no queueing.
- kill in any state: next state IDLE, busy 0, done 0; result keeps its previous value. kill overrides a simultaneous start.
- kill together with FIX: no done pulse and result is not updated.
- op, a and b are don't-care except on the accepting edge.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: for MUL/MULH, when the remaining unshifted multiplier bits are all zero, CALC exits to FIX early. A zero multiplier gives done 2 cycles after start. Divide latency is unchanged.
- Undefined: fixed XLEN+2 latency for every non-special operation. Results are identical either way.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD): result 0xFFFFFFEB; done 34 cycles after start; stall high for the first 33 cycles.
- MULH a=0x80000000, b=0x80000000: result 0x40000000. MULH a=-1, b=1: result 0xFFFFFFFF.
- DIV a=-7, b=2: result 0xFFFFFFFD (-3). REM a=-7, b=2: result 0xFFFFFFFF (-1). Both after 34 cycles.
- DIV a=5, b=0: result 0xFFFFFFFF with 1-cycle latency. REM a=5, b=0: result 5. DIV a=0x80000000, b=-1: result 0x80000000. REM with the same operands: result 0.
- Start DIV, pulse kill at cycle 10: no done, busy 0 the next cycle, result unchanged. Then start is accepted and runs normally.
- Back-to-back: start held high on the DONE cycle with MUL 3*4: the second done arrives 34 cycles later with result 12. rst_n pulsed low mid-CALC: all outputs 0 immediately.
